// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty fetch sequencer and its watchdog.
package bitty_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_MEM = 3'd2,
        ST_EXEC     = 3'd3,
        ST_HALTED   = 3'd4
    } state_e;

    localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/bitty_watchdog.sv
// Counts consecutive enabled cycles; flags expiry on the TIMEOUT-th one.
module bitty_watchdog
    import bitty_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bitty_fetch_sequencer.sv
// Fetch/execute sequencer for the bitty core: fetches one word,
// holds run until the core signals done, then advances pc.
module bitty_fetch_sequencer
    import bitty_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(8'hFF),
    parameter bit                WRAP      = 1'b0,
    parameter int                TIMEOUT   = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              halt_req,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rd_data,
    input  logic              mem_rd_valid,
    output logic [15:0]       instruction,
    output logic              run,
    input  logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr_count,
    output logic              busy,
    output logic              halted,
    output logic              error
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [15:0]       count_q, count_d;
    logic              run_q, run_d;
    logic              rd_en_q, rd_en_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              error_q, error_d;
    logic              pend_q, pend_d;

    logic              wd_expired;
    logic              at_last;
    logic [ADDR_W-1:0] pc_next;

    bitty_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != ST_EXEC),
        .enable  (state_q == ST_EXEC),
        .expired (wd_expired)
    );

    // Without WRAP the last address is sticky, so pc_next also covers halt-at-end.
    assign at_last = (pc_q == LAST_ADDR);
    assign pc_next = at_last ? (WRAP ? '0 : pc_q) : pc_q + ADDR_W'(1);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        count_d  = count_q;
        run_d    = run_q;
        error_d  = error_q;
        pend_d   = pend_q;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    pc_d    = start_addr;
                    error_d = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                pend_d  = pend_q | halt_req;
                state_d = ST_WAIT_MEM;
            end
            ST_WAIT_MEM: begin
                pend_d = pend_q | halt_req;
                if (mem_rd_valid) begin
                    instr_d = mem_rd_data;
                    run_d   = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                pend_d = pend_q | halt_req;
                if (done) begin
                    run_d   = 1'b0;
                    count_d = (count_q == 16'hFFFF) ? count_q
                                                    : count_q + 16'd1;
                    pc_d    = pc_next;
                    if (pend_q || halt_req || (at_last && !WRAP)) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else if (wd_expired) begin
                    run_d   = 1'b0;
                    error_d = 1'b1;
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_HALTED) begin
            pend_d = 1'b0;
        end
        rd_en_d  = (state_d == ST_FETCH);
        halted_d = (state_d == ST_HALTED);
        busy_d   = (state_d == ST_FETCH) || (state_d == ST_WAIT_MEM)
                || (state_d == ST_EXEC);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            count_q  <= '0;
            run_q    <= 1'b0;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            count_q  <= count_d;
            run_q    <= run_d;
            rd_en_q  <= rd_en_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            error_q  <= error_d;
            pend_q   <= pend_d;
        end
    end

    assign mem_rd_en   = rd_en_q;
    assign mem_addr    = pc_q;
    assign instruction = instr_q;
    assign run         = run_q;
    assign pc          = pc_q;
    assign instr_count = count_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign error       = error_q;

endmodule

// File: tb/tb_bitty_fetch_sequencer.sv
// Scoreboard bench: expected fetch addresses and instruction words are
// queued as stimulus is driven and checked as the sequencer produces them.
module tb_bitty_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, halt_req, mem_rd_valid, done;
    logic [7:0]  start_addr;
    logic [15:0] mem_rd_data;
    logic        mem_rd_en, run, busy, halted, error;
    logic [7:0]  mem_addr, pc;
    logic [15:0] instruction, instr_count;

    logic        start1, valid1, done1;
    logic        mem_rd_en_1, run_1, busy_1, halted_1, error_1;
    logic [7:0]  mem_addr_1, pc_1;
    logic [15:0] instruction_1, instr_count_1;

    int          n_checks = 0;
    int          n_errs = 0;
    int          exp_count = 0;
    logic [7:0]  addr_q[$];
    logic [15:0] instr_q[$];

    always #5 clk = ~clk;

    bitty_fetch_sequencer #(.WRAP(1'b0)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .halt_req(halt_req), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
        .instruction(instruction), .run(run), .done(done), .pc(pc),
        .instr_count(instr_count), .busy(busy), .halted(halted),
        .error(error)
    );

    bitty_fetch_sequencer #(.WRAP(1'b1)) dut_wrap (
        .clk(clk), .reset(reset), .start(start1), .start_addr(start_addr),
        .halt_req(1'b0), .mem_rd_en(mem_rd_en_1), .mem_addr(mem_addr_1),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(valid1),
        .instruction(instruction_1), .run(run_1), .done(done1), .pc(pc_1),
        .instr_count(instr_count_1), .busy(busy_1), .halted(halted_1),
        .error(error_1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start(input logic [7:0] a);
        start_addr = a;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_fetch(output bit ok);
        int i;
        i = 0;
        while (!mem_rd_en && i < 20) begin
            tick();
            i++;
        end
        ok = mem_rd_en;
        if (!ok) chk("fetch_timeout", 0, 1);
    endtask

    task automatic do_instr(input int lat, input int dly, input bit stray,
                            input bit hreq);
        bit          ok;
        logic [7:0]  ea;
        logic [15:0] w, ei;
        wait_fetch(ok);
        if (!ok) return;
        ea = addr_q.pop_front();
        chk("fetch_addr", mem_addr, ea);
        w = {ea ^ 8'h5A, ~ea};
        for (int k = 0; k < lat; k++) begin
            tick();
            chk("rd_en_pulse", mem_rd_en, 0);
            chk("run_wait_mem", run, 0);
        end
        mem_rd_data = w;
        mem_rd_valid = 1'b1;
        instr_q.push_back(w);
        tick();
        mem_rd_valid = 1'b0;
        ei = instr_q.pop_front();
        chk("run_rise", run, 1);
        chk("instr", instruction, ei);
        for (int k = 0; k < dly; k++) begin
            if (stray && k == 0) begin
                mem_rd_data = 16'hDEAD;
                mem_rd_valid = 1'b1;
            end
            if (hreq && k == 1) halt_req = 1'b1;
            tick();
            mem_rd_valid = 1'b0;
            halt_req = 1'b0;
            chk("run_hold", run, 1);
            chk("instr_hold", instruction, ei);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        exp_count++;
        chk("run_fall", run, 0);
        chk("count", instr_count, exp_count);
    endtask

    task automatic no_fetch(input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (mem_rd_en) seen++;
        end
        chk("no_fetch", seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1);
    end

    initial begin
        bit ok;
        int n;
        reset = 1'b1; start = 1'b0; halt_req = 1'b0; mem_rd_valid = 1'b0;
        done = 1'b0; start_addr = 8'h00; mem_rd_data = 16'h0000;
        start1 = 1'b0; valid1 = 1'b0; done1 = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_pc", pc, 0);
        chk("rst_run", run, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_error", error, 0);
        chk("rst_instr", instruction, 0);

        done = 1'b1;
        tick();
        done = 1'b0;
        chk("idle_done_count", instr_count, 0);
        chk("idle_done_busy", busy, 0);

        do_start(8'h10);
        chk("busy_fetch", busy, 1);
        addr_q.push_back(8'h10);
        addr_q.push_back(8'h11);
        addr_q.push_back(8'h12);
        do_instr(1, 3, 1'b0, 1'b0);
        do_instr(1, 3, 1'b0, 1'b0);
        do_instr(1, 3, 1'b0, 1'b1);
        chk("a_pc", pc, 8'h13);
        chk("a_halted", halted, 1);

        do_start(8'h04);
        chk("b_halted_clr", halted, 0);
        addr_q.push_back(8'h04);
        addr_q.push_back(8'h05);
        do_instr(5, 3, 1'b1, 1'b0);
        do_instr(1, 3, 1'b0, 1'b1);
        chk("b_pc", pc, 8'h06);
        chk("b_halted", halted, 1);
        chk("b_busy", busy, 0);
        no_fetch(8);

        do_start(8'hFF);
        addr_q.push_back(8'hFF);
        do_instr(1, 2, 1'b0, 1'b0);
        chk("end_pc", pc, 8'hFF);
        chk("end_halted", halted, 1);
        no_fetch(5);

        do_start(8'h20);
        wait_fetch(ok);
        chk("wd_addr", mem_addr, 8'h20);
        tick();
        mem_rd_data = 16'h1357;
        mem_rd_valid = 1'b1;
        tick();
        mem_rd_valid = 1'b0;
        n = 0;
        while (run && n < 40) begin
            n++;
            tick();
        end
        chk("wd_cycles", n, 15);
        chk("wd_error", error, 1);
        chk("wd_halted", halted, 1);
        chk("wd_pc", pc, 8'h20);
        chk("wd_count", instr_count, exp_count);

        do_start(8'h30);
        chk("restart_error", error, 0);
        chk("restart_halted", halted, 0);
        addr_q.push_back(8'h30);
        do_instr(1, 3, 1'b0, 1'b0);

        wait_fetch(ok);
        chk("rst_mid_addr", mem_addr, 8'h31);
        tick();
        mem_rd_data = 16'hBEEF;
        mem_rd_valid = 1'b1;
        tick();
        mem_rd_valid = 1'b0;
        chk("rst_mid_run", run, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_count = 0;
        chk("mid_pc", pc, 0);
        chk("mid_run", run, 0);
        chk("mid_instr", instruction, 0);
        chk("mid_count", instr_count, 0);
        chk("mid_busy", busy, 0);
        chk("mid_rd_en", mem_rd_en, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("post_rst_done_count", instr_count, 0);
        chk("post_rst_done_busy", busy, 0);

        halt_req = 1'b1;
        do_start(8'h40);
        halt_req = 1'b0;
        addr_q.push_back(8'h40);
        addr_q.push_back(8'h41);
        do_instr(1, 3, 1'b0, 1'b0);
        chk("start_wins_halted", halted, 0);
        do_instr(1, 2, 1'b0, 1'b1);
        chk("start_wins_pc", pc, 8'h42);

        start_addr = 8'hFF;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("wrap_rd_en", mem_rd_en_1, 1);
        chk("wrap_addr0", mem_addr_1, 8'hFF);
        tick();
        mem_rd_data = 16'h1234;
        valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        chk("wrap_run", run_1, 1);
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        chk("wrap_pc", pc_1, 8'h00);
        chk("wrap_refetch", mem_rd_en_1, 1);
        chk("wrap_addr1", mem_addr_1, 8'h00);
        chk("wrap_halted", halted_1, 0);
        chk("wrap_count", instr_count_1, 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/bitty_fetch_sequencer.md
BITTY_FETCH_SEQUENCER -- requirements
Module: bitty_fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, program-counter/memory address width.
REQ-002 SHALL have parameter LAST_ADDR, default 8'hFF, final program address.
REQ-003 SHALL have parameter WRAP, default 0; 1 = wrap to 0 after LAST_ADDR, 0 = halt.
REQ-004 SHALL have parameter TIMEOUT, default 15, maximum EXEC cycles allowed before done.
REQ-005 SHALL use clock clk; reset reset, synchronous, active-high.
REQ-006 SHALL have ports (name  direction  width  meaning):
 clk  in  1  clock
 reset  in  1  sync active-high reset
 start  in  1  one-cycle pulse; load pc from start_addr and begin fetching
 start_addr  in  ADDR_W  first program address
 halt_req  in  1  stop at next instruction boundary
 mem_rd_en  out  1  one-cycle read strobe
 mem_addr  out  ADDR_W  read address (= pc)
 mem_rd_data  in  16  instruction word
 mem_rd_valid  in  1  mem_rd_data valid this cycle
 instruction  out  16  word presented to the core's control unit
 run  out  1  core run enable
 done  in  1  core completion pulse
 pc  out  ADDR_W  current program counter
 instr_count  out  16  retired-instruction count, saturating
 busy  out  1  state not IDLE/HALTED
 halted  out  1  in HALTED
 error  out  1  sticky timeout flag

Function
REQ-007 SHALL implement states IDLE, FETCH, WAIT_MEM, EXEC, HALTED; all outputs registered.
REQ-008 IDLE/HALTED + start=1: pc<=start_addr, error<=0, halted<=0, next FETCH; start ignored in other states.
REQ-009 FETCH: mem_rd_en=1 for exactly one cycle, mem_addr=pc, next WAIT_MEM.
REQ-010 WAIT_MEM: wait any number of cycles; on mem_rd_valid=1 latch instruction<=mem_rd_data, run<=1, next EXEC; mem_rd_valid SHALL be ignored in every other state.
REQ-011 EXEC: run held 1 and instruction held stable until done sampled 1.
REQ-012 On done=1 in EXEC, at that same edge: run<=0, instr_count<=instr_count+1 (saturate at 16'hFFFF), then boundary decision per REQ-013..015; core therefore sees run=1 during its done cycle and never starts a second instruction.
REQ-013 Boundary, halt pending: pc<=pc+1 (or wrap per REQ-014), next HALTED.
REQ-014 Boundary, pc==LAST_ADDR: WRAP=1 -> pc<=0, next FETCH; WRAP=0 -> pc unchanged, next HALTED.
REQ-015 Boundary, otherwise: pc<=pc+1, next FETCH.
REQ-016 halt_req SHALL set a pending flag in FETCH/WAIT_MEM/EXEC, honoured only at the boundary; cleared on entry to HALTED; ignored in IDLE/HALTED.
REQ-017 Watchdog counts EXEC cycles; reaching TIMEOUT without done -> run<=0, error<=1, next HALTED, pc and instr_count unchanged.
REQ-018 done sampled outside EXEC SHALL be ignored.
REQ-019 start and halt_req in same IDLE cycle: start wins, halt ignored.

Reset
REQ-020 reset=1 at any edge, including mid-EXEC: state IDLE, pc=0, instruction=0, run=0, mem_rd_en=0, instr_count=0, busy=0, halted=0, error=0, halt pending=0, watchdog=0.

Structure
REQ-021 State encoding and default TIMEOUT SHALL live in shared package bitty_pkg.
REQ-022 Watchdog SHALL be sub-module bitty_watchdog (clear, enable, expired); all else in one module.

Verification
REQ-023 start_addr=0x10, memory 1-cycle latency, core done 3 cycles after run: mem_rd_en at pc 0x10,0x11,0x12...; run falls the edge done is seen; instr_count increments per done.
REQ-024 Memory latency 5 cycles: run stays 0 until mem_rd_valid; stray mem_rd_valid during EXEC changes nothing.
REQ-025 halt_req pulsed during EXEC at pc=0x05: after done, pc=0x06, halted=1, no further mem_rd_en; start resumes from new start_addr.
REQ-026 WRAP=0, start_addr=LAST_ADDR=0xFF: one instruction retires, halted=1, pc=0xFF; WRAP=1: next fetch at 0x00.
REQ-027 Core never asserts done: after 15 EXEC cycles run=0, error=1, halted=1; next start clears error.
REQ-028 reset asserted mid-EXEC: next cycle all outputs at REQ-020 values; done arriving afterwards ignored.
